fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch stage plus instruction queue, sitting between the combinational instruction ROM and decode/dispatch of the Tomasulo core.
- Owns the PC and drives the ROM byte address. Each fetched word is captured with its PC in a circular FIFO.
- The FIFO presents entries to dispatch through a valid/ready handshake.
- A redirect (branch resolution / mispredict from the CDB side) flushes the queue and reloads the PC.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 1024, ROM size in bytes; fetch stops at the end of ROM.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  32  byte address to instruction ROM; always equals the PC register.
- imem_instr  in  32  combinational ROM read data for imem_addr.
- redirect_valid  in  1  flush and reload PC this cycle.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  head entry available to dispatch.
- out_ready  in  1  dispatch accepts head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of head instruction.
- fetch_done  out  1  PC beyond ROM; no further fetches until redirect.

Behaviour:
- Reset (rst_n=0 at posedge), whole cycle:
  - pc=RESET_PC; head=tail=0; count=0.
  - Outputs: out_valid=0, fetch_done=0.
  - out_instr and out_pc are don't-care while out_valid=0.
  - rst_n has priority over redirect_valid.
- State: pc[31:0]; head and tail pointers, $clog2(DEPTH) bits, natural wrap; count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- in_range = (pc + 3 < IMEM_BYTES), computed in 33-bit arithmetic so there is no overflow alias. fetch_done = !in_range.
- fetch_en = !redirect_valid && in_range && (count < DEPTH).
  - No full-bypass: a dequeue in the same cycle does not free a slot for that cycle's fetch.
- deq = out_valid && out_ready.
- out_valid = (count != 0) && !redirect_valid.
- out_instr and out_pc come from the head entry register; there is no combinational path from imem_instr.
- Latency: a word fetched at posedge N (pc sampled in cycle N) is visible with out_valid=1 in cycle N+1 at the earliest.
- fetch_en at posedge: mem[tail] <= {pc, imem_instr}; tail++; pc <= pc+4.
- deq at posedge: head++.
- count update: +1 on fetch only, -1 on deq only, unchanged if both or neither.
- redirect_valid at posedge (rst_n=1):
  - head=tail=0, count=0, pc <= {redirect_pc[31:2],2'b00}.
  - No fetch or dequeue is recorded that cycle.
  - The first new instruction appears 2 cycles after redirect assertion: fetched in cycle R+1, visible in R+2.
  - Back-to-back redirects: the last one wins, and the queue stays empty throughout.
- Full (count==DEPTH): pc holds, imem_addr stable, no write.
- Empty: out_valid=0; out_ready is ignored.
- End of ROM: pc holds at the first out-of-range address, the queue drains normally, and a redirect to a valid PC clears fetch_done.
- imem_instr is X while out of range; never write it into the queue.
- Assertions (simulation only):
  - count <= DEPTH.
  - out_ready with out_valid=0 must not change state.
  - imem_addr[1:0]==0 always.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32.
  - INSTR_BYTES=4.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- One natural sub-module: sync_fifo.
  - Parameters: type/width, DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, flush.
- fetch_queue then holds only the PC logic, the range check and the handshake gating (~150 lines total).

Test Plan:
1. Reset then out_ready=1, ROM words W0..W3 at 0x0..0xC → out_valid rises in cycle 2 after reset release; outputs (0x0,W0),(0x4,W1),(0x8,W2),(0xC,W3) on consecutive cycles.
2. out_ready=0 for 20 cycles, DEPTH=8 → count saturates at 8, imem_addr holds at 0x20, out_pc stays 0x0; raise out_ready → 8 entries drain in order, fetch resumes at 0x20.
3. Queue holding 5 entries, redirect_valid=1 with redirect_pc=0x43 (misaligned) → out_valid=0 that cycle; next cycle imem_addr=0x40, count=0; (0x40,mem[16]) appears 2 cycles after redirect.
4. Redirect to 0x3F8 with IMEM_BYTES=1024 → entries 0x3F8 and 0x3FC are enqueued, then pc=0x400 holds and fetch_done=1; a later redirect to 0x0 clears fetch_done.
5. Full queue with deq and redirect in the same cycle → the redirect wins: count=0, and head/tail do not advance from the dequeue.
6. rst_n=0 asserted mid-stream with redirect_valid=1 → pc=RESET_PC, count=0, out_valid=0 the next cycle; redirect_pc ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core package: machine word width, instruction size and the fetch
// queue entry format (PC of the instruction plus the fetched word).
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with flush.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empty the queue this cycle (overrides wr_en / rd_en)
//   wr_en      : push wr_data at tail
//   rd_en      : pop head (caller must only assert when count != 0)
//   rd_data    : head entry, straight from storage (registered)
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter type T     = logic [63:0],
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  T                       wr_data,
    input  logic                   rd_en,
    output T                       rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) tail_d = tail_q + PTR_ONE;
            if (rd_en) head_d = head_q + PTR_ONE;
            // Simultaneous push and pop leaves occupancy unchanged.
            if (wr_en && !rd_en) count_d = count_q + CNT_ONE;
            if (!wr_en && rd_en) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_en) mem_q[tail_q] <= wr_data;
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_MAX);
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
        (rd_en && !flush) |-> (count_q != '0));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        (wr_en && !flush && !rd_en) |-> (count_q != CNT_MAX));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage plus instruction queue.
// Owns the PC, addresses the combinational instruction ROM, captures each
// fetched word with its PC in a FIFO and offers the head to dispatch.
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_addr         : ROM byte address (the PC register)
//   imem_instr        : ROM read data for imem_addr
//   redirect_valid/pc : flush queue and reload PC (low two bits dropped)
//   out_valid/ready   : dispatch handshake for the head entry
//   out_instr/out_pc  : head entry contents
//   fetch_done        : PC past end of ROM; idle until redirected
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH      = 8,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [XLEN:0]   ROM_END  = (XLEN+1)'(IMEM_BYTES);
    localparam logic [XLEN:0]   LAST_OFS = (XLEN+1)'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN    = ~XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            in_range;
    logic            fetch_en;
    logic            deq;
    logic [AW:0]     count;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head_entry;

    // Whole word must lie inside the ROM; the extra bit keeps pc+3 from
    // wrapping back into range near the top of the address space.
    assign in_range = ({1'b0, pc_q} + LAST_OFS) < ROM_END;

    // No full-bypass: a same-cycle dequeue does not open a slot for fetch.
    assign fetch_en  = !redirect_valid && in_range && (count < FULL_CNT);
    assign out_valid = rst_n && (count != '0) && !redirect_valid;
    assign deq       = out_valid && out_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)  pc_d = redirect_pc & ALIGN;
        else if (fetch_en)   pc_d = pc_q + PC_STEP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign wr_entry = '{pc: pc_q, instr: imem_instr};

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .wr_en   (fetch_en),
        .wr_data (wr_entry),
        .rd_en   (deq),
        .rd_data (head_entry),
        .count   (count)
    );

    assign imem_addr  = pc_q;
    assign out_instr  = head_entry.instr;
    assign out_pc     = head_entry.pc;
    assign fetch_done = rst_n && !in_range;

    a_pc_aligned : assert property (@(posedge clk) disable iff (!rst_n)
        imem_addr[1:0] == 2'b00);
    a_idle_ready : assert property (@(posedge clk) disable iff (!rst_n)
        (out_ready && !out_valid && !redirect_valid && !fetch_en)
        |=> (count == $past(count)) && (imem_addr == $past(imem_addr)));

endmodule
